// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg : pixel widths, Q8 colour-space coefficients and shared helpers
// Rev 1.0
// ============================================================================
package video_pkg;

    localparam int PIX_W      = 8;
    localparam int CHROMA_OFS = 128;
    localparam int ACC_W      = 20;

    // YCbCr -> RGB (BT.601 full range, Q8)
    localparam int Q8_CR_R = 359;
    localparam int Q8_CB_G = 88;
    localparam int Q8_CR_G = 183;
    localparam int Q8_CB_B = 454;

    // RGB -> YCbCr (BT.601 full range, Q8), magnitudes; signs live in the forward converter
    localparam int Q8_Y_R    = 77;
    localparam int Q8_Y_G    = 150;
    localparam int Q8_Y_B    = 29;
    localparam int Q8_FCB_R  = 43;
    localparam int Q8_FCB_G  = 85;
    localparam int Q8_FCB_B  = 128;
    localparam int Q8_FCR_R  = 128;
    localparam int Q8_FCR_G  = 107;
    localparam int Q8_FCR_B  = 21;

    function automatic logic [PIX_W-1:0] clamp_u8(input int v);
        if (v < 0) begin
            return '0;
        end else if (v > 255) begin
            return '1;
        end else begin
            return PIX_W'(v);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycbcr2rgb_if.sv
`default_nettype none
// ============================================================================
// ycbcr2rgb_if : YCbCr pixel/sync input and RGB pixel/sync output bundle
// Rev 1.0
// ============================================================================
interface ycbcr2rgb_if;
    import video_pkg::*;

    logic [PIX_W-1:0] y_i;
    logic [PIX_W-1:0] cb_i;
    logic [PIX_W-1:0] cr_i;
    logic             de_i;
    logic             hsync_i;
    logic             vsync_i;
    logic             gray_en;
    logic [PIX_W-1:0] rgb_r;
    logic [PIX_W-1:0] rgb_g;
    logic [PIX_W-1:0] rgb_b;
    logic             de_o;
    logic             hsync_o;
    logic             vsync_o;

    modport master (
        output y_i, cb_i, cr_i, de_i, hsync_i, vsync_i, gray_en,
        input  rgb_r, rgb_g, rgb_b, de_o, hsync_o, vsync_o
    );

    modport slave (
        input  y_i, cb_i, cr_i, de_i, hsync_i, vsync_i, gray_en,
        output rgb_r, rgb_g, rgb_b, de_o, hsync_o, vsync_o
    );

endinterface
`default_nettype wire

// File: rtl/ycbcr2rgb_sync_delay.sv
`default_nettype none
// ============================================================================
// sync_delay : fixed-depth resettable shift register for de/hsync/vsync
// Rev 1.0
// ============================================================================
module sync_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  wire              sclk,
    input  wire              s_rst_n,
    input  wire  [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] taps_q [DEPTH];

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            taps_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign q_o = taps_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ycbcr2rgb.sv
`default_nettype none
// ============================================================================
// ycbcr2rgb : 3-stage BT.601 full-range YCbCr -> RGB888 with grey and blanking
// Rev 1.0
// ============================================================================
module ycbcr2rgb
    import video_pkg::*;
#(
    parameter int CR_R  = Q8_CR_R,
    parameter int CB_G  = Q8_CB_G,
    parameter int CR_G  = Q8_CR_G,
    parameter int CB_B  = Q8_CB_B,
    parameter int ACC_W = video_pkg::ACC_W
) (
    input  wire        sclk,
    input  wire        s_rst_n,
    ycbcr2rgb_if.slave vid
);

    localparam logic signed [ACC_W-1:0] K_CR_R = ACC_W'(CR_R);
    localparam logic signed [ACC_W-1:0] K_CB_G = ACC_W'(CB_G);
    localparam logic signed [ACC_W-1:0] K_CR_G = ACC_W'(CR_G);
    localparam logic signed [ACC_W-1:0] K_CB_B = ACC_W'(CB_B);
    localparam logic signed [ACC_W-1:0] K_RND  = ACC_W'(128);

    // stage 1
    logic signed [8:0]       dcb_d, dcr_d, dcb_q, dcr_q;
    logic signed [ACC_W-1:0] yq1_d, yq1_q;
    logic [PIX_W-1:0]        y1_q;
    logic                    gray1_q, de1_q;
    // stage 2
    logic signed [ACC_W-1:0] dcb_x, dcr_x;
    logic signed [ACC_W-1:0] pr_d, pgb_d, pgr_d, pb_d;
    logic signed [ACC_W-1:0] pr_q, pgb_q, pgr_q, pb_q, yq2_q;
    logic [PIX_W-1:0]        y2_q;
    logic                    gray2_q, de2_q;
    // stage 3
    logic signed [ACC_W-1:0] s_r, s_g, s_b;
    logic [PIX_W-1:0]        r_d, g_d, b_d, r_q, g_q, b_q;
    logic [2:0]              sync_q;

    always_comb begin
        dcb_d = $signed({1'b0, vid.cb_i} - 9'(CHROMA_OFS));
        dcr_d = $signed({1'b0, vid.cr_i} - 9'(CHROMA_OFS));
        yq1_d = $signed(ACC_W'({vid.y_i, 8'h00}));
    end

    always_comb begin
        dcb_x = ACC_W'(dcb_q);
        dcr_x = ACC_W'(dcr_q);
        pr_d  = K_CR_R * dcr_x;
        pgb_d = K_CB_G * dcb_x;
        pgr_d = K_CR_G * dcr_x;
        pb_d  = K_CB_B * dcb_x;
    end

    // Blanking wins over grey so inactive video is always black.
    always_comb begin
        s_r = yq2_q + pr_q + K_RND;
        s_g = yq2_q - pgb_q - pgr_q + K_RND;
        s_b = yq2_q + pb_q + K_RND;
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de2_q) begin
            if (gray2_q) begin
                r_d = y2_q;
                g_d = y2_q;
                b_d = y2_q;
            end else begin
                r_d = clamp_u8(int'(s_r >>> 8));
                g_d = clamp_u8(int'(s_g >>> 8));
                b_d = clamp_u8(int'(s_b >>> 8));
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            dcb_q   <= '0;
            dcr_q   <= '0;
            yq1_q   <= '0;
            y1_q    <= '0;
            gray1_q <= 1'b0;
            de1_q   <= 1'b0;
            pr_q    <= '0;
            pgb_q   <= '0;
            pgr_q   <= '0;
            pb_q    <= '0;
            yq2_q   <= '0;
            y2_q    <= '0;
            gray2_q <= 1'b0;
            de2_q   <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            dcb_q   <= dcb_d;
            dcr_q   <= dcr_d;
            yq1_q   <= yq1_d;
            y1_q    <= vid.y_i;
            gray1_q <= vid.gray_en;
            de1_q   <= vid.de_i;
            pr_q    <= pr_d;
            pgb_q   <= pgb_d;
            pgr_q   <= pgr_d;
            pb_q    <= pb_d;
            yq2_q   <= yq1_q;
            y2_q    <= y1_q;
            gray2_q <= gray1_q;
            de2_q   <= de1_q;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    sync_delay #(
        .DEPTH (3),
        .WIDTH (3)
    ) u_sync_delay (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .d_i     ({vid.de_i, vid.hsync_i, vid.vsync_i}),
        .q_o     (sync_q)
    );

    assign vid.rgb_r   = r_q;
    assign vid.rgb_g   = g_q;
    assign vid.rgb_b   = b_q;
    assign vid.de_o    = sync_q[2];
    assign vid.hsync_o = sync_q[1];
    assign vid.vsync_o = sync_q[0];

endmodule
`default_nettype wire

// File: tb/tb_ycbcr2rgb.sv
`default_nettype none
// ============================================================================
// tb_ycbcr2rgb : scoreboard bench for the YCbCr -> RGB converter
// Rev 1.0
// ============================================================================
module tb_ycbcr2rgb;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    logic sclk    = 1'b0;
    logic s_rst_n = 1'b0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ycbcr2rgb_if bus();

    ycbcr2rgb dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .vid     (bus)
    );

    always #5 sclk = ~sclk;

    function automatic logic [7:0] sat(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic exp_t model(input int y, input int cb, input int cr,
                                   input bit de, input bit hs, input bit vs, input bit gr);
        exp_t e;
        int   r, g, b;
        r = (y * 256 + 359 * (cr - 128) + 128) >>> 8;
        g = (y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128) >>> 8;
        b = (y * 256 + 454 * (cb - 128) + 128) >>> 8;
        e.de = de;
        e.hs = hs;
        e.vs = vs;
        if (!de) begin
            e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
        end else if (gr) begin
            e.r = 8'(y); e.g = 8'(y); e.b = 8'(y);
        end else begin
            e.r = sat(r); e.g = sat(g); e.b = sat(b);
        end
        return e;
    endfunction

    function automatic exp_t observed();
        return {bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.de_o, bus.hsync_o, bus.vsync_o};
    endfunction

    // One clock: score the pixel leaving the pipe, then present a new one.
    task automatic drive_pixel(input int y, input int cb, input int cr,
                               input bit de, input bit hs, input bit vs, input bit gr);
        exp_t e, a;
        @(negedge sclk);
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            a = observed();
            n_checks++;
            if (a !== e)
                $display("FAIL pixel_out t=%0t: got r=%0d g=%0d b=%0d de=%b hs=%b vs=%b, expected r=%0d g=%0d b=%0d de=%b hs=%b vs=%b",
                         $time, a.r, a.g, a.b, a.de, a.hs, a.vs, e.r, e.g, e.b, e.de, e.hs, e.vs);
            else
                n_pass++;
        end
        bus.y_i     = 8'(y);
        bus.cb_i    = 8'(cb);
        bus.cr_i    = 8'(cr);
        bus.de_i    = de;
        bus.hsync_i = hs;
        bus.vsync_i = vs;
        bus.gray_en = gr;
        exp_q.push_back(model(y, cb, cr, de, hs, vs, gr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_pixel(0, 128, 128, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_reset();
        bus.y_i = '0; bus.cb_i = '0; bus.cr_i = '0;
        bus.de_i = 1'b0; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0; bus.gray_en = 1'b0;
        @(negedge sclk);
        s_rst_n = 1'b1;
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
    endtask

    task automatic test_reset();
        bus.y_i = 8'd200; bus.cb_i = 8'd10; bus.cr_i = 8'd250;
        bus.de_i = 1'b1; bus.hsync_i = 1'b1; bus.vsync_i = 1'b1; bus.gray_en = 1'b0;
        repeat (4) @(negedge sclk);
        n_checks++;
        if (observed() !== exp_t'(0))
            $display("FAIL reset_state: got %h, expected 0", observed());
        else
            n_pass++;
        release_reset();
    endtask

    task automatic test_mid_grey();
        drive_pixel(128, 128, 128, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        n_checks++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.de_o} !== {8'd128, 8'd128, 8'd128, 1'b1})
            $display("FAIL mid_grey: got r=%0d g=%0d b=%0d de=%b, expected 128/128/128 de=1",
                     bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.de_o);
        else
            n_pass++;
    endtask

    task automatic test_clamp();
        drive_pixel(255, 128, 255, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_pixel(0, 128, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_pixel(0, 0, 128, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_pixel(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b} !== {8'd255, 8'd164, 8'd255})
            $display("FAIL red_sat: got %0d/%0d/%0d, expected 255/164/255", bus.rgb_r, bus.rgb_g, bus.rgb_b);
        else
            n_pass++;
        drive_pixel(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b} !== {8'd0, 8'd92, 8'd0})
            $display("FAIL neg_clamp_cr: got %0d/%0d/%0d, expected 0/92/0", bus.rgb_r, bus.rgb_g, bus.rgb_b);
        else
            n_pass++;
        drive_pixel(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b} !== {8'd0, 8'd44, 8'd0})
            $display("FAIL neg_clamp_cb: got %0d/%0d/%0d, expected 0/44/0", bus.rgb_r, bus.rgb_g, bus.rgb_b);
        else
            n_pass++;
        idle(1);
    endtask

    task automatic test_ramp_latency();
        for (int i = 0; i < 259; i++) begin
            if (i < 256) drive_pixel(i, 128, 128, 1'b1, i == 0, 1'b0, 1'b0);
            else         drive_pixel(0, 128, 128, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i < 8) begin
                n_checks++;
                if (bus.hsync_o !== (i == 3))
                    $display("FAIL hsync_align i=%0d: got %b, expected %b", i, bus.hsync_o, (i == 3));
                else
                    n_pass++;
            end
            if (i >= 3) begin
                n_checks++;
                if (bus.rgb_r !== 8'(i - 3) || bus.rgb_g !== 8'(i - 3) || bus.rgb_b !== 8'(i - 3))
                    $display("FAIL ramp i=%0d: got %0d/%0d/%0d, expected %0d", i, bus.rgb_r, bus.rgb_g, bus.rgb_b, i - 3);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_gray_blank();
        drive_pixel(200, 0, 255, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_pixel(200, 0, 255, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        n_checks++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b} !== {8'd200, 8'd200, 8'd200})
            $display("FAIL gray: got %0d/%0d/%0d, expected 200/200/200", bus.rgb_r, bus.rgb_g, bus.rgb_b);
        else
            n_pass++;
        idle(1);
        n_checks++;
        if ({bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.de_o} !== 25'd0)
            $display("FAIL blank: got %0d/%0d/%0d de=%b, expected 0/0/0 de=0", bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.de_o);
        else
            n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            drive_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 5) == 0);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) drive_pixel(128, 128, 128, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        s_rst_n = 1'b0;
        #1;
        n_checks++;
        if (observed() !== exp_t'(0))
            $display("FAIL async_reset: got %h, expected 0", observed());
        else
            n_pass++;
        repeat (2) @(negedge sclk);
        release_reset();
        for (int k = 0; k < 6; k++) begin
            drive_pixel(128, 128, 128, 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bus.rgb_r !== ((k >= 3) ? 8'd128 : 8'd0))
                $display("FAIL post_reset k=%0d: got r=%0d, expected %0d", k, bus.rgb_r, (k >= 3) ? 128 : 0);
            else
                n_pass++;
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_mid_grey();
        test_clamp();
        test_ramp_latency();
        test_gray_blank();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
